// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register with valid/ready handshake, flush (branch kill),
// bubble control-gating and a saturating stall-cycle counter.
//
// Build option: define SKID_BUFFER_EN for a 2-entry (main + skid) buffer
// whose in_ready is a flop output, which removes the combinational path
// from out_ready to in_ready. Without it a single entry is held and
// in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             kill held and incoming contents this cycle
//   in_valid/in_ready decode-side handshake
//   in_pc, in_instr, in_rs1, in_rs2, in_imm, in_ctrl   decoded payload
//   out_valid/out_ready execute-side handshake
//   out_pc, out_instr, out_rs1, out_rs2, out_imm       held payload
//   out_ctrl          held control, forced to 0 whenever out_valid=0
//   stall_cnt         saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [ILEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_rs1,
  output logic [XLEN-1:0]   out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = 4 * XLEN + ILEN + CTRL_W;

  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     main_reg;
  logic [CTRL_W-1:0] held_ctrl;
  logic              valid_w;
  logic              accept;
  logic [CNT_W-1:0]  stall_cnt_reg;

  assign in_payload = {in_pc, in_instr, in_rs1, in_rs2, in_imm, in_ctrl};

`ifdef SKID_BUFFER_EN

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t        state_reg, state_next;
  logic          in_ready_reg;
  logic [PW-1:0] skid_reg;
  logic          load_main_in, load_main_skid, load_skid_in;

  assign in_ready = in_ready_reg;
  assign valid_w  = (state_reg != EMPTY);
  // Flush wins over accept: an incoming word during flush is discarded.
  assign accept   = in_valid & in_ready_reg & ~flush;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next   = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (accept && out_ready) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next   = FULL;
            load_skid_in = 1'b1;
          end else if (out_ready) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // Older entry in main drains first; skid moves up behind it.
          if (out_ready) begin
            state_next     = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
      main_reg     <= '0;
      skid_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered ready: it depends only on the next state, not on out_ready
      // combinationally.
      in_ready_reg <= (state_next != FULL);
      if (load_main_in) begin
        main_reg <= in_payload;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid_in) begin
        skid_reg <= in_payload;
      end
    end
  end

`else

  logic valid_reg;

  assign valid_w  = valid_reg;
  assign in_ready = ~valid_reg | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      main_reg  <= '0;
    end else if (flush) begin
      // Payload keeps stale data; out_ctrl is gated by valid.
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      main_reg  <= in_payload;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

`endif

  // Stall counter: saturates, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (valid_w && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign out_valid = valid_w;
  assign {out_pc, out_instr, out_rs1, out_rs2, out_imm, held_ctrl} = main_reg;

  // A bubble must never present live control bits downstream.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign out_ctrl[gi] = held_ctrl[gi] & valid_w;
    end
  endgenerate

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Self-checking bench for id_ex_pipe_reg. A FIFO reference model (capacity
// 1, or 2 with SKID_BUFFER_EN) predicts out_valid, payload, in_ready and the
// stall count. Counter width is reduced to 4 to reach saturation quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam int XLEN   = 32;
  localparam int ILEN   = 32;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [8:0]  ctrl;
  } ent_t;

  logic clk, rst, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [31:0] in_pc, in_instr, in_rs1, in_rs2, in_imm;
  logic [8:0]  in_ctrl;
  logic [31:0] out_pc, out_instr, out_rs1, out_rs2, out_imm;
  logic [8:0]  out_ctrl;
  logic [3:0]  stall_cnt;

  ent_t cur;
  ent_t mq[$];
  bit   m_rdy;
  int   m_cnt;
  int   n_checks;
  int   n_fail;

  assign in_pc    = cur.pc;
  assign in_instr = cur.instr;
  assign in_rs1   = cur.rs1;
  assign in_rs2   = cur.rs2;
  assign in_imm   = cur.imm;
  assign in_ctrl  = cur.ctrl;

  id_ex_pipe_reg #(
    .XLEN(XLEN), .ILEN(ILEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_in_ready();
`ifdef SKID_BUFFER_EN
    return m_rdy;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  function automatic bit e_valid();
    return mq.size() > 0;
  endfunction

  function automatic ent_t e_out();
    ent_t e;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    return e;
  endfunction

  function automatic ent_t rnd_ent(input logic [31:0] pc);
    ent_t e;
    e.pc    = pc;
    e.instr = $urandom;
    e.rs1   = $urandom;
    e.rs2   = $urandom;
    e.imm   = $urandom;
    e.ctrl  = 9'($urandom);
    return e;
  endfunction

  // Advance one clock edge and update the model from the inputs seen there.
  task automatic step();
    bit rdy, acc, cons;
    rdy  = m_in_ready();
    acc  = in_valid && rdy && !flush;
    cons = (mq.size() > 0) && out_ready && !flush;
    if ((mq.size() > 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (cons) begin
        $display("xfer out pc=%08h instr=%08h ctrl=%03h", mq[0].pc, mq[0].instr, mq[0].ctrl);
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(cur);
    end
    m_rdy = (mq.size() < 2);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    cur       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_rdy = 1'b0;
    m_cnt = 0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ent_t got;
    do_reset();
    cur = rnd_ent(32'h40); cur.ctrl = 9'h1FF;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid);
    end
    #3;
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    got = {out_pc, out_instr, out_rs1, out_rs2, out_imm, out_ctrl};
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    n_checks++;
    if (got !== ent_t'(0)) begin
      n_fail++; $display("FAIL reset_payload got=%h exp=0", got);
    end
    n_checks++;
    if (stall_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    end
    @(posedge clk);
    #1;
    n_checks++;
`ifdef SKID_BUFFER_EN
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
`else
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
`endif
    rst = 1'b0;
    idle_inputs();
    mq.delete(); m_rdy = 1'b0; m_cnt = 0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur = rnd_ent(32'(i * 4));
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_ctrl !== e_out().ctrl) begin
        n_fail++;
        $display("FAIL stream_out[%0d] got v=%b pc=%h ctrl=%h exp v=1 pc=%h ctrl=%h",
                 i, out_valid, out_pc, out_ctrl, i * 4, e_out().ctrl);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 9'h0) begin
      n_fail++; $display("FAIL stream_drain got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cur = rnd_ent(32'h10);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    cur = rnd_ent(32'h14);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== m_in_ready()) begin
        n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", i, in_ready, m_in_ready());
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b pc=%h exp v=1 pc=10", i, out_valid, out_pc);
      end
    end
    n_checks++;
    if (stall_cnt !== 4'd3) begin
      n_fail++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
`ifdef SKID_BUFFER_EN
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h14) begin
      n_fail++; $display("FAIL bp_release1 got v=%b pc=%h exp v=1 pc=14", out_valid, out_pc);
    end
    step();
`endif
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release_empty got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cur = rnd_ent(32'h20);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    cur = rnd_ent(32'h24); cur.ctrl = 9'h1FF;
    flush = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 9'h0) begin
      n_fail++; $display("FAIL flush_kill got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, out_ctrl);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 9'h0) begin
        n_fail++; $display("FAIL flush_after[%0d] got v=%b pc=%h exp v=0", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    cur = rnd_ent(32'h30); cur.ctrl = 9'h1FF;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 9'h0) begin
        n_fail++; $display("FAIL bubble[%0d] got v=%b ctrl=%h exp v=0 ctrl=0", i, out_valid, out_ctrl);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    cur = rnd_ent(32'h50);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (stall_cnt !== 4'(m_cnt)) begin
        n_fail++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, m_cnt);
      end
    end
    n_checks++;
    if (stall_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_final got=%0d exp=15", stall_cnt);
    end
  endtask

  task automatic test_random();
    ent_t got, exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cur = rnd_ent($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      n_checks++;
      if (in_ready !== m_in_ready()) begin
        n_fail++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, m_in_ready());
      end
      step();
      got = {out_pc, out_instr, out_rs1, out_rs2, out_imm, out_ctrl};
      exp = e_out();
      n_checks++;
      if (out_valid !== e_valid()) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, e_valid());
      end
      n_checks++;
      if (e_valid() && got !== exp) begin
        n_fail++; $display("FAIL rnd_payload[%0d] got=%h exp=%h", i, got, exp);
      end else if (!e_valid() && out_ctrl !== 9'h0) begin
        n_fail++; $display("FAIL rnd_bubble_ctrl[%0d] got=%h exp=0", i, out_ctrl);
      end
      n_checks++;
      if (stall_cnt !== 4'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_rdy    = 1'b0;
    m_cnt    = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
